alu_scheduler: RTL and testbench



---
 rtl/alu_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// -----------------------------------------------------------------------------
// alu_scheduler
//
// Front-end for a shared 32-bit ALU. Two requesters submit operations through
// valid/ready handshakes. The block grants them round-robin, registers the
// operands, holds them on the ALU for a per-opcode latency, and returns the
// registered 64-bit result with the requester id on one response channel.
//
// Ports
//   clk                    : single clock, rising edge
//   rst                    : synchronous reset, active-high
//   req0_valid/req1_valid  : requester presents an operation
//   req0_ready/req1_ready  : operation accepted this cycle (combinational)
//   reqN_a / reqN_b        : 32-bit operands
//   reqN_op                : 3-bit ALU opcode
//   reqN_cin               : carry-in, used by opcode 000 only
//   rsp_valid              : response available
//   rsp_ready              : consumer accepts the response
//   rsp_id                 : index of the issuing requester
//   rsp_data               : 64-bit result
//   rsp_dz                 : divide-by-zero flag
//
// Also contains the alu module that the scheduler instantiates.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu: purely combinational 32-bit ALU with a 64-bit result.
//   000 A+B+cin (33-bit)   001 A-B (32-bit wrap)   010 A*B (64-bit)
//   011 A/B                100 A%B                 101 A&B
//   110 A|B                111 A+B (33-bit)
// All narrow results are zero-extended. Division by zero returns 0 here; the
// scheduler overrides that case anyway.
// -----------------------------------------------------------------------------
module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    input  logic        cin_i,
    output logic [63:0] out_o
);
    logic [32:0] sum_cin_s;
    logic [32:0] sum_s;

    assign sum_cin_s = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
    assign sum_s     = {1'b0, a_i} + {1'b0, b_i};

    // Opcode decode of the result.
    always_comb begin
        out_o = 64'd0;
        case (op_i)
            3'b000:  out_o = {31'd0, sum_cin_s};
            3'b001:  out_o = {32'd0, a_i - b_i};
            3'b010:  out_o = {32'd0, a_i} * {32'd0, b_i};
            3'b011:  out_o = (b_i == 32'd0) ? 64'd0 : {32'd0, a_i / b_i};
            3'b100:  out_o = (b_i == 32'd0) ? 64'd0 : {32'd0, a_i % b_i};
            3'b101:  out_o = {32'd0, a_i & b_i};
            3'b110:  out_o = {32'd0, a_i | b_i};
            3'b111:  out_o = {31'd0, sum_s};
            default: out_o = 64'd0;
        endcase
    end
endmodule

module alu_scheduler #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_data,
    output logic        rsp_dz
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        cin_q, cin_d;
    logic        id_q, id_d;
    logic        dz_q, dz_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_dz_q, rsp_dz_d;

    logic        grant_s;
    logic        idle_s;
    logic        accept_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [2:0]  sel_op_s;
    logic        sel_cin_s;
    logic        sel_dz_s;
    logic [63:0] alu_out_s;

    // Returns L-1 for an opcode; a divide by zero completes in one cycle.
    function automatic logic [3:0] exec_cnt(input logic [2:0] op, input logic dz);
        logic [3:0] c;
        if (dz) begin
            c = 4'd0;
        end else begin
            case (op)
                3'b010:         c = 4'(MUL_CYCLES - 1);
                3'b011, 3'b100: c = 4'(DIV_CYCLES - 1);
                default:        c = 4'd0;
            endcase
        end
        return c;
    endfunction

    alu u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .cin_i (cin_q),
        .out_o (alu_out_s)
    );

    // Round-robin grant; on a tie the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is suppressed while reset is asserted so nothing is handshaken then.
    assign idle_s     = (state_q == IDLE) && !rst;
    assign accept_s   = idle_s && (req0_valid || req1_valid);
    assign req0_ready = idle_s && req0_valid && (grant_s == 1'b0);
    assign req1_ready = idle_s && req1_valid && (grant_s == 1'b1);

    assign sel_a_s   = grant_s ? req1_a   : req0_a;
    assign sel_b_s   = grant_s ? req1_b   : req0_b;
    assign sel_op_s  = grant_s ? req1_op  : req0_op;
    assign sel_cin_s = grant_s ? req1_cin : req0_cin;
    assign sel_dz_s  = ((sel_op_s == 3'b011) || (sel_op_s == 3'b100)) && (sel_b_s == 32'd0);

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cin_d       = cin_q;
        id_d        = id_q;
        dz_d        = dz_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_dz_d    = rsp_dz_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = sel_a_s;
                    b_d     = sel_b_s;
                    op_d    = sel_op_s;
                    cin_d   = sel_cin_s;
                    id_d    = grant_s;
                    dz_d    = sel_dz_s;
                    last_d  = grant_s;
                    cnt_d   = exec_cnt(sel_op_s, sel_dz_s);
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = dz_q ? 64'd0 : alu_out_s;
                    rsp_dz_d    = dz_q;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b1;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 3'd0;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            dz_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 64'd0;
            rsp_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            dz_q        <= dz_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_dz    = rsp_dz_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed, table-driven bench for alu_scheduler (MUL_CYCLES=2, DIV_CYCLES=8).
module tb_alu_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        req0_cin, req1_cin;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_dz;
    logic [63:0] rsp_data;

    int checks = 0;
    int failures = 0;

    alu_scheduler #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_dz(rsp_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [63:0] exp_data;
        logic        exp_dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, check latency and response fields, then consume it.
    task automatic do_op(input vec_t v);
        int k;
        bit seen;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_valid = (v.id == 1'b0);
        req1_valid = (v.id == 1'b1);
        req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_cin = v.cin;
        req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_cin = v.cin;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        chk({v.name, "_accept"}, {63'd0, seen}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
        k = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        chk({v.name, "_rsp_seen"}, {63'd0, seen}, 64'd1);
        chk({v.name, "_latency"}, 64'(k), 64'(v.lat + 1));
        chk({v.name, "_data"}, rsp_data, v.exp_data);
        chk({v.name, "_id"}, {63'd0, rsp_id}, {63'd0, v.id});
        chk({v.name, "_dz"}, {63'd0, rsp_dz}, {63'd0, v.exp_dz});
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic [63:0] held_data;
        logic        held_id;
        logic        got;
        logic        exp_id;
        int          k;
        bit          stray;

        vecs[0]  = '{"add_carry", 1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1, 1'b1, 64'h1_0000_0001, 1'b0, 1};
        vecs[1]  = '{"mul_max",   1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0, 2};
        vecs[2]  = '{"div_zero",  1'b0, 3'b011, 32'd100, 32'd0, 1'b0, 64'd0, 1'b1, 1};
        vecs[3]  = '{"mod_7",     1'b1, 3'b100, 32'd100, 32'd7, 1'b0, 64'd2, 1'b0, 8};
        vecs[4]  = '{"sub_wrap",  1'b0, 3'b001, 32'd5, 32'd7, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1};
        vecs[5]  = '{"div_7",     1'b1, 3'b011, 32'd100, 32'd7, 1'b0, 64'd14, 1'b0, 8};
        vecs[6]  = '{"and",       1'b0, 3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 64'h0000_0000_F000_F000, 1'b0, 1};
        vecs[7]  = '{"or",        1'b1, 3'b110, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0, 64'h0000_0000_FFFF_F0F0, 1'b0, 1};
        vecs[8]  = '{"add_nocin", 1'b0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1_FFFF_FFFE, 1'b0, 1};
        vecs[9]  = '{"mod_zero",  1'b0, 3'b100, 32'd5, 32'd0, 1'b0, 64'd0, 1'b1, 1};
        vecs[10] = '{"add_small", 1'b1, 3'b000, 32'd3, 32'd4, 1'b0, 64'd7, 1'b0, 1};

        // Reset with both valids high: no ready, outputs at reset values.
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 3'b000; req0_cin = 1'b0;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 3'b000; req1_cin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        end
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_dz", {63'd0, rsp_dz}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 11; i++) do_op(vecs[i]);

        // Round-robin with backpressure on the first response.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;  req0_op = 3'b000; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 3'b000; req1_cin = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp_id = n[0];
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("rr_accept%0d", n), {63'd0, got}, 64'd1);
            chk($sformatf("rr_grant%0d", n), {62'd0, req1_ready, req0_ready},
                exp_id ? 64'd2 : 64'd1);
            @(posedge clk); #1;
            if (n == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("rr_rsp%0d", n), {63'd0, got}, 64'd1);
            chk($sformatf("rr_id%0d", n), {63'd0, rsp_id}, {63'd0, exp_id});
            chk($sformatf("rr_data%0d", n), rsp_data, exp_id ? 64'd30 : 64'd2);
            if (n == 0) begin
                held_data = rsp_data;
                held_id = rsp_id;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
                    chk("stall_data", rsp_data, held_data);
                    chk("stall_id", {63'd0, rsp_id}, {63'd0, held_id});
                    chk("stall_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
                end
            end
            rsp_ready = 1'b1;
            if (n < 3) begin
                // Next accept must occur in the cycle right after the handshake.
                @(posedge clk); #1;
                k = 0;
            end
        end
        @(posedge clk); #1;

        // Reset three cycles after accepting a divide: no response may appear.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd3; req0_op = 3'b011; req0_cin = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstx_accept", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) stray = 1'b1;
        end
        chk("rstx_no_rsp", {63'd0, stray}, 64'd0);
        do_op('{"after_rst", 1'b1, 3'b011, 32'd9, 32'd3, 1'b0, 64'd3, 1'b0, 8});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
